scan_sequencer: RTL and testbench

- Drives the one-bit mode input `x` of the four-state reset/run/shift/update TAP state machine.
- Performs one scan transaction per `start` pulse:
  - walks the TAP from Reset or Run/Idle into Shift;
  - shifts `len` bits out on `sdo` while capturing `sdi`;
  - exits through Update and parks in Run/Idle.
- Closed-loop: it observes the TAP's one-hot state flags, gates data movement on them, and reports completion or a timeout error to the host.

---
 rtl/scan_pkg.sv | 30 +++
 rtl/scan_shreg.sv | 43 ++++
 rtl/scan_sequencer.sv | 162 ++++++++++++++++
 tb/tb_scan_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan sequencer.
// Holds TAP flag encodings, sequencer states, default latency/timeout and a length clamp.
package scan_pkg;

    typedef enum logic [3:0] {
        TAP_RS = 4'b0001,
        TAP_RI = 4'b0010,
        TAP_SH = 4'b0100,
        TAP_UP = 4'b1000
    } tap_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO_RI,
        S_GO_SH,
        S_SHIFT,
        S_EXIT
    } seq_e;

    localparam int LAT_DEF = 2;
    localparam int TMO_DEF = 8;

    // Zero means one bit; anything past the register width is cut to it.
    function automatic int clamp_len(input int l, input int w);
        if (l < 1) return 1;
        if (l > w) return w;
        return l;
    endfunction

endpackage

// File: rtl/scan_shreg.sv
// Load/shift register with serial in/out and a bit down-counter.
// Ports: clk, rs, load/shift/clr controls, din/num load values, sdi in; sreg, cnt, sdo out.
module scan_shreg
    import scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             load,
    input  logic             shift,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic [LW-1:0]    num,
    input  logic             sdi,
    output logic [WIDTH-1:0] sreg,
    output logic [LW-1:0]    cnt,
    output logic             sdo
);

    // sdo is registered: it is loaded with the bit the next qualified
    // cycle will present, and drops to 0 once the count is exhausted.
    always_ff @(posedge clk) begin
        if (rs) begin
            sreg <= '0;
            cnt  <= '0;
            sdo  <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            sdo <= 1'b0;
        end else if (load) begin
            sreg <= din;
            cnt  <= num;
            sdo  <= din[0];
        end else if (shift && cnt != '0) begin
            sreg <= {sdi, sreg[WIDTH-1:1]};
            cnt  <= cnt - LW'(1);
            sdo  <= (cnt != LW'(1)) && sreg[1];
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Closed-loop scan sequencer driving the mode bit of a 4-state TAP.
// Ports: clk, rs, start/len/din host request, tap_* flags, sdi; x, sdo, dout, busy, done, err.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LAT   = LAT_DEF,
    parameter int TMO   = TMO_DEF,
    localparam int LW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             start,
    input  logic [LW-1:0]    len,
    input  logic [WIDTH-1:0] din,
    input  logic             tap_reset,
    input  logic             tap_run,
    input  logic             tap_shift,
    input  logic             tap_update,
    input  logic             sdi,
    output logic             x,
    output logic             sdo,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int IW = $clog2(TMO + 1);

    seq_e             state;
    seq_e             st_n;
    logic [IW-1:0]    idle;
    logic [IW-1:0]    idle_n;
    logic [LW-1:0]    lenq;
    logic [LW-1:0]    clen;
    logic [LW-1:0]    cnt;
    logic [LW-1:0]    cnt_n;
    logic [WIDTH-1:0] sreg;
    logic             ld;
    logic             qual;
    logic             last;
    logic             waiting;
    logic             fin;
    logic             abort;
    logic             x_n;

    assign clen = LW'(clamp_len(int'(len), WIDTH));
    assign ld   = (state == S_IDLE) && start;
    assign qual = tap_shift && (cnt != '0)
               && (state == S_GO_SH || state == S_SHIFT);
    assign last  = (cnt == LW'(1));
    assign cnt_n = qual ? cnt - LW'(1) : cnt;

    scan_shreg #(
        .WIDTH (WIDTH),
        .LW    (LW)
    ) u_shreg (
        .clk   (clk),
        .rs    (rs),
        .load  (ld),
        .shift (qual),
        .clr   (abort),
        .din   (din),
        .num   (clen),
        .sdi   (sdi),
        .sreg  (sreg),
        .cnt   (cnt),
        .sdo   (sdo)
    );

    always_comb begin
        st_n    = state;
        idle_n  = '0;
        fin     = 1'b0;
        abort   = 1'b0;
        waiting = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) st_n = S_GO_RI;
            end
            S_GO_RI: begin
                waiting = !tap_run;
                if (tap_run) st_n = S_GO_SH;
            end
            S_GO_SH: begin
                waiting = !tap_shift;
                if (tap_shift) st_n = last ? S_EXIT : S_SHIFT;
            end
            S_SHIFT: begin
                waiting = !tap_shift;
                if (tap_reset) abort = 1'b1;
                else if (qual && last) st_n = S_EXIT;
            end
            S_EXIT: begin
                waiting = !tap_update;
                if (tap_reset) begin
                    abort = 1'b1;
                end else if (tap_update) begin
                    st_n = S_IDLE;
                    fin  = 1'b1;
                end
            end
            default: st_n = S_IDLE;
        endcase
        if (waiting) begin
            if (idle == IW'(TMO - 1)) abort = 1'b1;
            else idle_n = idle + IW'(1);
        end
        if (abort) begin
            st_n   = S_IDLE;
            fin    = 1'b0;
            idle_n = '0;
        end
    end

    // x is registered from the next state so the value seen in a cycle
    // follows that cycle's state and pre-decrement count.
    always_comb begin
        x_n = x;
        unique case (st_n)
            S_IDLE:  x_n = abort ? 1'b1 : x;
            S_GO_RI: x_n = 1'b0;
            S_GO_SH: x_n = 1'b1;
            S_SHIFT: x_n = int'(cnt_n) > LAT - 1;
            S_EXIT:  x_n = 1'b0;
            default: x_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            state <= S_IDLE;
            idle  <= '0;
            lenq  <= '0;
            x     <= 1'b1;
            dout  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= st_n;
            idle  <= idle_n;
            x     <= x_n;
            done  <= fin || abort;
            if (ld) begin
                lenq <= clen;
                busy <= 1'b1;
                err  <= 1'b0;
            end
            if (fin) begin
                busy <= 1'b0;
                dout <= sreg >> (LW'(WIDTH) - lenq);
            end
            if (abort) begin
                busy <= 1'b0;
                err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer against a behavioural TAP model.
// Expected results are queued at issue and checked by a monitor on done.
module tb_scan_sequencer;
    import scan_pkg::*;

    localparam int W   = 8;
    localparam int LAT = 2;
    localparam int TMO = 8;
    localparam int LW  = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rs;
    logic          start;
    logic [LW-1:0] len;
    logic [W-1:0]  din;
    logic          tap_reset, tap_run, tap_shift, tap_update;
    logic          sdi;
    logic          x, sdo, busy, done, err;
    logic [W-1:0]  dout;

    always #5 clk = ~clk;

    scan_sequencer #(.WIDTH(W), .LAT(LAT), .TMO(TMO)) dut (
        .clk(clk), .rs(rs), .start(start), .len(len), .din(din),
        .tap_reset(tap_reset), .tap_run(tap_run), .tap_shift(tap_shift),
        .tap_update(tap_update), .sdi(sdi), .x(x), .sdo(sdo),
        .dout(dout), .busy(busy), .done(done), .err(err)
    );

    // TAP model: state moves on x each edge, flags lag by LAT-1 more edges.
    tap_e pipe [LAT];
    logic freeze;

    function automatic tap_e tnext(input tap_e s, input logic m);
        case (s)
            TAP_RS:  return m ? TAP_RS : TAP_RI;
            TAP_RI:  return m ? TAP_SH : TAP_RI;
            TAP_SH:  return m ? TAP_SH : TAP_UP;
            TAP_UP:  return m ? TAP_SH : TAP_RI;
            default: return TAP_RS;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rs || freeze) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= TAP_RS;
        end else begin
            pipe[0] <= tnext(pipe[0], x);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {tap_update, tap_shift, tap_run, tap_reset} = pipe[LAT-1];

    typedef struct {
        logic [W-1:0] d;
        logic         e;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           passes = 0;
    int           ndone  = 0;
    int           qi     = 0;
    int           cur_l  = 0;
    logic [W-1:0] cur_din, cur_rdat, last_exp;
    bit           cur_loop, in_txn;
    logic         acc_done;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: pops on done, checks sdo on TAP shift cycles, drives sdi.
    initial begin
        exp_t e;
        sdi = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("done_expected", 32'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("dout", 32'(dout), 32'(e.d));
                    chk("err", 32'(err), 32'(e.e));
                end
                in_txn = 1'b0;
            end
            if (in_txn && tap_shift) begin
                if (qi < cur_l) begin
                    chk("sdo_bit", 32'(sdo), 32'(cur_din[qi]));
                    sdi = cur_loop ? sdo : cur_rdat[qi];
                    qi++;
                end else begin
                    chk("sdo_overshoot", 32'(sdo), 0);
                end
            end
        end
    end

    task automatic issue(input int l, input logic [W-1:0] d, input bit lp,
                         input logic [W-1:0] r, input bit tmo);
        int n;
        int eff;
        logic [W-1:0] m;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("issue_wait", 32'(busy), 0);
        acc_done = done;
        len   = LW'(l);
        din   = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        eff = (l < 1) ? 1 : (l > W) ? W : l;
        m = W'((32'h1 << eff) - 1);
        cur_l = eff; cur_din = d; cur_loop = lp; cur_rdat = r;
        qi = 0; in_txn = 1'b1;
        if (tmo) begin
            e.d = last_exp;
            e.e = 1'b1;
        end else begin
            e.d = lp ? (d & m) : (r & m);
            e.e = 1'b0;
            last_exp = e.d;
        end
        sbq.push_back(e);
    endtask

    task automatic wait_done(input int n0);
        int c;
        c = 0;
        while (ndone <= n0 && c < 300) begin
            @(negedge clk);
            #1 c++;
        end
        chk("done_seen", 32'(ndone > n0), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0, c;
        rs = 1'b1; start = 1'b0; len = '0; din = '0; freeze = 1'b0;
        last_exp = '0; in_txn = 1'b0; acc_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", 32'(x), 1);
        chk("rst_sdo", 32'(sdo), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        start = 1'b1; din = 8'hFF; len = LW'(8);
        @(posedge clk);
        #1 chk("rs_beats_start", 32'(busy), 0);
        start = 1'b0; rs = 1'b0;

        // basic looped shift
        n0 = ndone;
        issue(8, 8'hA5, 1'b1, 8'h00, 1'b0);
        chk("busy_after_accept", 32'(busy), 1);
        chk("x_after_accept", 32'(x), 0);
        wait_done(n0);
        repeat (3) @(negedge clk);
        chk("tap_parks_run", 32'(tap_run), 1);
        chk("x_parked", 32'(x), 0);

        // short scan, sdi held high
        n0 = ndone;
        issue(3, 8'h06, 1'b0, 8'hFF, 1'b0);
        wait_done(n0);

        // timeout with TAP held in reset
        freeze = 1'b1;
        n0 = ndone;
        issue(8, 8'h11, 1'b1, 8'h00, 1'b1);
        repeat (TMO - 1) @(posedge clk);
        #1 chk("tmo_not_early", 32'(done), 0);
        @(posedge clk);
        #1 chk("tmo_done", 32'(done), 1);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_busy", 32'(busy), 0);
        @(posedge clk);
        #1 chk("tmo_x", 32'(x), 1);
        chk("tmo_dout_kept", 32'(dout), 32'h07);
        repeat (3) @(posedge clk);
        #1 chk("err_sticky", 32'(err), 1);
        freeze = 1'b0;

        // busy start ignored, then back-to-back in the done cycle
        n0 = ndone;
        issue(8, 8'h3C, 1'b1, 8'h00, 1'b0);
        chk("err_cleared", 32'(err), 0);
        repeat (5) @(posedge clk);
        #1 begin start = 1'b1; din = 8'hFF; len = LW'(2); end
        @(posedge clk);
        #1 start = 1'b0;
        issue(8, 8'hC3, 1'b1, 8'h00, 1'b0);
        chk("b2b_in_done_cycle", 32'(acc_done), 1);
        wait_done(n0 + 1);

        // length clamping
        n0 = ndone;
        issue(0, 8'h5A, 1'b0, 8'hB3, 1'b0);
        wait_done(n0);
        n0 = ndone;
        issue(15, 8'h96, 1'b1, 8'h00, 1'b0);
        wait_done(n0);

        // randomized transactions
        for (int i = 0; i < 20; i++) begin
            n0 = ndone;
            issue(int'($urandom_range(0, 15)), W'($urandom),
                  1'($urandom_range(0, 1)), W'($urandom), 1'b0);
            wait_done(n0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // reset in the middle of a shift
        issue(8, 8'hE7, 1'b1, 8'h00, 1'b0);
        c = 0;
        while (qi < 3 && c < 200) begin
            @(posedge clk);
            #1 c++;
        end
        chk("mid_reach", 32'(qi >= 3), 1);
        rs = 1'b1;
        in_txn = 1'b0;
        void'(sbq.pop_back());
        last_exp = '0;
        @(posedge clk);
        #1 rs = 1'b0;
        chk("mid_x", 32'(x), 1);
        chk("mid_sdo", 32'(sdo), 0);
        chk("mid_dout", 32'(dout), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_err", 32'(err), 0);
        n0 = ndone;
        repeat (30) @(posedge clk);
        #1 chk("mid_no_done", 32'(ndone), 32'(n0));
        chk("mid_dout_hold", 32'(dout), 0);
        chk("queue_empty", 32'(sbq.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
